i2c_regfile_target: RTL and testbench
=====================================

# i2c_regfile_target

Parametrised I2C target (slave) with an internal byte-wide register bank, sub-address pointer and auto-increment. It is the next-generation replacement for the fixed-map I2C slave in the dice project. It sits between the uio I2C pads (SDA on uio[2], SCL on uio[3]) and the design logic. It exposes every register as a flat parallel bus and emits a write strobe per accepted data byte.

## Interface
- `DEV_ADDR`, default 7'h70: 7-bit target address (write address byte 0xE0, read address byte 0xE1).
- `N_REGS`, default 128: number of 8-bit registers, 1..256.
- `WRAP`, default 1: 1 means the pointer wraps from N_REGS-1 to 0; 0 means the pointer counts modulo 256.
- `SYNC_STAGES`, default 2: synchroniser depth on SCL/SDA, minimum 2.
- `clk` in 1: system clock, at least 16× SCL rate.
- `rst_n` in 1: reset; asynchronous, active-low.
- `scl_in` in 1: SCL pad input.
- `sda_in` in 1: SDA pad input.
- `sda_oe` out 1: 1 pulls SDA low; the pad output value is tied to 0 (open-drain).
- `regs_flat` out 8*N_REGS: register contents; reg k is at [8k+7:8k].
- `wr_pulse` out 1: one-cycle strobe per accepted data byte.
- `wr_addr` out 8: pointer value for that byte.
- `wr_data` out 8: the byte written.
- `busy` out 1: high from address match until STOP or return to IDLE.

## Operation
- **Inputs:** SCL and SDA pass through SYNC_STAGES flops (reset value 1), then one history flop.
- **Events detected:** SCL rise, SCL fall, START (SDA falls while SCL high), STOP (SDA rises while SCL high).
- **Bit timing:** bits are sampled on SCL rise. sda_oe changes only on SCL fall, or on START/STOP, when it is released.
- **State machine:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
  - START from any state goes to ADDR. The bit counter is cleared and the pointer is kept, so a repeated START preserves the pointer.
  - STOP from any state goes to IDLE with sda_oe=0.
  - ADDR: shift 8 bits MSB first.
    - On the SCL fall after bit 8: if addr[7:1]==DEV_ADDR, go to ADDR_ACK and drive sda_oe=1.
    - Otherwise go to WAIT and never drive.
  - ADDR_ACK, on SCL fall: release. A W bit goes to PTR. An R bit loads the shift register from reg[ptr] and goes to RDATA.
  - PTR: after 8 bits, load the pointer and ACK (PTR_ACK), then go to WDATA.
  - WDATA: after 8 bits, ACK.
    - If ptr < N_REGS, write reg[ptr] and assert wr_pulse/wr_addr/wr_data.
    - Out-of-range bytes are ACKed and discarded, with no wr_pulse.
    - Then increment ptr.
  - RDATA: drive sda_oe = ~shift[7] on each SCL fall and shift on SCL rise.
    - After 8 bits, release SDA and go to RDATA_ACK.
    - Out-of-range reads return 8'hFF.
  - RDATA_ACK: sample SDA on SCL rise.
    - 0 (ACK): increment ptr, load the next byte, return to RDATA.
    - 1 (NAK): go to WAIT.
  - WAIT: SDA released; leave only on START or STOP.
- **Pointer increment:** ptr+1. If WRAP=1 and ptr==N_REGS-1, the next value is 0. Otherwise the pointer counts 8-bit modulo 256.
- **Reset (async, any time, including mid-transfer):**
  - State IDLE, ptr 0, all regs 8'h00, sda_oe 0, wr_pulse 0, wr_addr 0, wr_data 0, busy 0.
  - Sync flops go to 1, so no false START is seen on release.

## Timing
- Edge-detect latency: SYNC_STAGES+1 clk after the pad change.
- The ACK/data drive change appears at sda_oe 1 clk after SCL-fall detect.
- Register write, wr_pulse and ptr increment happen in the same clk, 1 clk after the detected SCL fall closing the 8th data bit. wr_pulse is exactly 1 cycle wide.
- The read byte is loaded in the clk of the SCL fall ending ADDR_ACK or RDATA_ACK. It is stable before the next SCL rise.
- A START and an SCL edge detected in the same clk: START wins.
- A STOP mid-byte discards the partial byte; no write occurs.

## Structure
- **Package `i2c_tgt_pkg`:** state enum, ACK=1'b0 / NAK=1'b1, the READ_BIT constant, and the `OOR_READ=8'hFF` constant.
- **Sub-module `i2c_line_sync`:**
  - Parametrised by SYNC_STAGES.
  - Outputs scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det.
  - Reused by any future I2C block.
- **Top:** FSM, bit counter (3 bits), shift register, pointer, register array.

## Test plan
- **Multi-byte write with ACK checks:** write 0xE0, ptr 10, 0x55, 0x1F.
  - All 4 bytes are ACKed.
  - regs[10]=0x55 and regs[11]=0x1F.
  - Two wr_pulses occur, with wr_addr 10 then 11.
- **Wrap on write:** write 0xE0, ptr 127, 0xFA, 0x4D with WRAP=1.
  - regs[127]=0xFA and regs[0]=0x4D.
  - With WRAP=0, regs[0] is unchanged and the second byte is ACKed with no wr_pulse.
- **Read with repeated START:** write 0xE0, ptr 126, repeated START, 0xE1, then read 3 bytes (master ACK, ACK, NAK).
  - The bytes return regs[126], regs[127], regs[0].
  - SDA is released after the NAK and busy drops at STOP.
- **Address mismatch:** send 0xC0 and data.
  - sda_oe stays 0 throughout.
  - No wr_pulse and no register change.
- **Out of range:** with N_REGS=16, write ptr 20 with 0xAA, then read from ptr 20.
  - The write is ACKed with no wr_pulse.
  - The read returns 0xFF.
- **Abort and reset:**
  - STOP after 4 bits of a data byte leaves the register unchanged.
  - Asserting rst_n=0 mid-read forces sda_oe=0 and clears all regs to 0x00 immediately (asynchronously).

Source files
------------

// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_tgt_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT
  } i2c_state_e;

  localparam logic       ACK      = 1'b0;
  localparam logic       NAK      = 1'b1;
  localparam logic       READ_BIT = 1'b1;
  localparam logic [7:0] OOR_READ = 8'hFF;

  // Wraps at the last register when requested, otherwise counts modulo 256.
  function automatic logic [7:0] ptr_inc(input logic [7:0] ptr,
                                         input logic [7:0] last,
                                         input logic       wrap);
    return (wrap && (ptr == last)) ? 8'h00 : ptr + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA pads and derives edge, START and STOP events.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;

  // Flops reset to the idle-bus level so releasing reset never fakes a START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_regfile_target.sv
// I2C target with a byte-wide register bank, sub-address pointer and auto-increment.
module i2c_regfile_target
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h70,
  parameter int         N_REGS      = 128,
  parameter bit         WRAP        = 1'b1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [8*N_REGS-1:0]   regs_flat,
  output logic                  wr_pulse,
  output logic [7:0]            wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy
);

  localparam int         IDX_W    = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [8:0] NREGS9   = 9'(N_REGS);
  localparam logic [7:0] LAST_PTR = 8'(N_REGS - 1);

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic unused_scl;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_s     (scl_s),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign unused_scl = scl_s;

  i2c_state_e state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       got8, got8_n;
  logic [7:0] shift, shift_n;
  logic [7:0] ptr, ptr_n;
  logic       rw, rw_n;
  logic       mack, mack_n;
  logic       sda_oe_n, busy_n, wr_pulse_n, reg_we;
  logic [7:0] wr_addr_n, wr_data_n;
  logic [7:0] regs [N_REGS];
  logic [7:0] ptr_nxt, rd_cur, rd_nxt;
  logic       cur_ok, nxt_ok;

  assign ptr_nxt = ptr_inc(ptr, LAST_PTR, WRAP);
  assign cur_ok  = {1'b0, ptr} < NREGS9;
  assign nxt_ok  = {1'b0, ptr_nxt} < NREGS9;
  assign rd_cur  = cur_ok ? regs[ptr[IDX_W-1:0]] : OOR_READ;
  assign rd_nxt  = nxt_ok ? regs[ptr_nxt[IDX_W-1:0]] : OOR_READ;

  for (genvar k = 0; k < N_REGS; k++) begin : g_flat
    assign regs_flat[8*k +: 8] = regs[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      got8     <= 1'b0;
      shift    <= '0;
      ptr      <= '0;
      rw       <= 1'b0;
      mack     <= NAK;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      got8     <= got8_n;
      shift    <= shift_n;
      ptr      <= ptr_n;
      rw       <= rw_n;
      mack     <= mack_n;
      sda_oe   <= sda_oe_n;
      busy     <= busy_n;
      wr_pulse <= wr_pulse_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_REGS; k++) regs[k] <= 8'h00;
    end else if (reg_we) begin
      regs[ptr[IDX_W-1:0]] <= shift;
    end
  end

  // START/STOP take priority over SCL edges; bits shift on rise, decisions and SDA drive on fall.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    got8_n     = got8;
    shift_n    = shift;
    ptr_n      = ptr;
    rw_n       = rw;
    mack_n     = mack;
    sda_oe_n   = sda_oe;
    busy_n     = busy;
    wr_pulse_n = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    reg_we     = 1'b0;
    if (start_det) begin
      state_n   = ST_ADDR;
      bit_cnt_n = '0;
      got8_n    = 1'b0;
      sda_oe_n  = 1'b0;
    end else if (stop_det) begin
      state_n   = ST_IDLE;
      bit_cnt_n = '0;
      got8_n    = 1'b0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (scl_rise) begin
      case (state)
        ST_ADDR, ST_PTR, ST_WDATA, ST_RDATA: begin
          if (!got8) begin
            shift_n   = {shift[6:0], sda_s};
            bit_cnt_n = bit_cnt + 3'd1;
            got8_n    = (bit_cnt == 3'd7);
          end
        end
        ST_RDATA_ACK: mack_n = sda_s;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        ST_ADDR: begin
          if (got8) begin
            got8_n = 1'b0;
            if (shift[7:1] == DEV_ADDR) begin
              state_n  = ST_ADDR_ACK;
              sda_oe_n = 1'b1;
              busy_n   = 1'b1;
              rw_n     = shift[0];
            end else begin
              state_n = ST_WAIT;
              busy_n  = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: begin
          sda_oe_n = 1'b0;
          if (rw == READ_BIT) begin
            shift_n  = rd_cur;
            sda_oe_n = ~rd_cur[7];
            state_n  = ST_RDATA;
          end else begin
            state_n = ST_PTR;
          end
        end
        ST_PTR: begin
          if (got8) begin
            got8_n   = 1'b0;
            ptr_n    = shift;
            sda_oe_n = 1'b1;
            state_n  = ST_PTR_ACK;
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          sda_oe_n = 1'b0;
          state_n  = ST_WDATA;
        end
        // Out-of-range bytes are still ACKed but never reach the bank.
        ST_WDATA: begin
          if (got8) begin
            got8_n   = 1'b0;
            sda_oe_n = 1'b1;
            if (cur_ok) begin
              reg_we     = 1'b1;
              wr_pulse_n = 1'b1;
              wr_addr_n  = ptr;
              wr_data_n  = shift;
            end
            ptr_n   = ptr_nxt;
            state_n = ST_WDATA_ACK;
          end
        end
        ST_RDATA: begin
          if (got8) begin
            got8_n   = 1'b0;
            sda_oe_n = 1'b0;
            state_n  = ST_RDATA_ACK;
          end else begin
            sda_oe_n = ~shift[7];
          end
        end
        ST_RDATA_ACK: begin
          if (mack == ACK) begin
            ptr_n    = ptr_nxt;
            shift_n  = rd_nxt;
            sda_oe_n = ~rd_nxt[7];
            state_n  = ST_RDATA;
          end else begin
            sda_oe_n = 1'b0;
            state_n  = ST_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_regfile_target.sv
// Table-driven bench: three targets on one bus (default, WRAP=0, N_REGS=16) driven by a bit-banged master.
module tb_i2c_regfile_target;

  localparam time Q = 40ns;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  wire  sda_line;

  logic oe0, oe1, oe2, busy0, busy1, busy2, wr0, wr1, wr2;
  logic [7:0] wa0, wd0, wa1, wd1, wa2, wd2;
  logic [8*128-1:0] regs0, regs1;
  logic [8*16-1:0]  regs2;

  int checks = 0;
  int errors = 0;
  int pulse_total = 0;
  int oe_cnt = 0;
  int long_pulses = 0;
  logic wr0_prev = 1'b0;
  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];

  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] ptr;
    logic [7:0] data;
    logic       exp_ack;
    logic       exp_data_ack;
    int         exp_pulses;
    int         dev;
    int         chk_idx;
    logic [7:0] exp_val;
  } vec_t;

  vec_t vecs [6];

  assign sda_line = sda_m & ~(oe0 | oe1 | oe2);

  always #5 clk = ~clk;

  i2c_regfile_target dut0 (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_line), .sda_oe(oe0),
    .regs_flat(regs0), .wr_pulse(wr0), .wr_addr(wa0), .wr_data(wd0), .busy(busy0)
  );

  i2c_regfile_target #(.DEV_ADDR(7'h71), .WRAP(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_line), .sda_oe(oe1),
    .regs_flat(regs1), .wr_pulse(wr1), .wr_addr(wa1), .wr_data(wd1), .busy(busy1)
  );

  i2c_regfile_target #(.DEV_ADDR(7'h72), .N_REGS(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_line), .sda_oe(oe2),
    .regs_flat(regs2), .wr_pulse(wr2), .wr_addr(wa2), .wr_data(wd2), .busy(busy2)
  );

  // Observes strobes and SDA drive on the falling clock edge, away from register updates.
  always @(negedge clk) begin
    if (wr0) begin
      pulse_total++;
      wa_q.push_back(wa0);
      wd_q.push_back(wd0);
    end
    if (wr1) pulse_total++;
    if (wr2) pulse_total++;
    if (oe0 | oe1 | oe2) oe_cnt++;
    if (wr0 && wr0_prev) long_pulses++;
    wr0_prev = wr0;
  end

  function automatic logic [7:0] get_reg(input int dev, input int idx);
    logic [7:0] r;
    case (dev)
      0:       r = regs0[idx*8 +: 8];
      1:       r = regs1[idx*8 +: 8];
      default: r = regs2[idx*8 +: 8];
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    sda_m = b;
    #Q scl = 1'b1;
    #Q s = sda_line;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    #Q scl = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      b[i] = s;
    end
    bit_cycle(mack, s);
  endtask

  task automatic applyStimulus(input vec_t v);
    int p0, o0;
    logic a;
    p0 = pulse_total;
    o0 = oe_cnt;
    i2c_start();
    write_byte(v.addr_byte, a);
    checkOutput("vec_addr_ack", 32'(a), 32'(v.exp_ack));
    write_byte(v.ptr, a);
    checkOutput("vec_ptr_ack", 32'(a), 32'(v.exp_ack));
    write_byte(v.data, a);
    checkOutput("vec_data_ack", 32'(a), 32'(v.exp_data_ack));
    i2c_stop();
    #200;
    checkOutput("vec_pulses", 32'(pulse_total - p0), 32'(v.exp_pulses));
    checkOutput("vec_reg", 32'(get_reg(v.dev, v.chk_idx)), 32'(v.exp_val));
    if (!v.exp_ack) checkOutput("vec_no_drive", 32'(oe_cnt - o0), 32'd0);
  endtask

  initial begin
    logic a;
    logic [7:0] rb;
    int p0;

    vecs[0] = '{8'hE0, 8'h03, 8'hA5, 1'b1, 1'b1, 1, 0, 3,  8'hA5};
    vecs[1] = '{8'hE2, 8'h05, 8'h3C, 1'b1, 1'b1, 1, 1, 5,  8'h3C};
    vecs[2] = '{8'hE4, 8'h0F, 8'h81, 1'b1, 1'b1, 1, 2, 15, 8'h81};
    vecs[3] = '{8'hE4, 8'h14, 8'hAA, 1'b1, 1'b1, 0, 2, 4,  8'h00};
    vecs[4] = '{8'hC0, 8'h03, 8'h11, 1'b0, 1'b0, 0, 0, 3,  8'hA5};
    vecs[5] = '{8'hE0, 8'h00, 8'hFF, 1'b1, 1'b1, 1, 0, 0,  8'hFF};

    #52 rst_n = 1'b1;
    #40;
    checkOutput("rst_sda_oe", 32'(oe0), 32'd0);
    checkOutput("rst_busy", 32'(busy0), 32'd0);
    checkOutput("rst_wr_pulse", 32'(wr0), 32'd0);
    checkOutput("rst_wr_addr", 32'(wa0), 32'd0);
    checkOutput("rst_regs_nonzero", 32'(|regs0), 32'd0);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Multi-byte write with auto-increment.
    wa_q.delete();
    wd_q.delete();
    i2c_start();
    write_byte(8'hE0, a); checkOutput("mb_addr_ack", 32'(a), 32'd1);
    write_byte(8'd10, a); checkOutput("mb_ptr_ack", 32'(a), 32'd1);
    write_byte(8'h55, a); checkOutput("mb_d0_ack", 32'(a), 32'd1);
    write_byte(8'h1F, a); checkOutput("mb_d1_ack", 32'(a), 32'd1);
    i2c_stop();
    #200;
    checkOutput("mb_reg10", 32'(get_reg(0, 10)), 32'h55);
    checkOutput("mb_reg11", 32'(get_reg(0, 11)), 32'h1F);
    checkOutput("mb_pulse_cnt", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      checkOutput("mb_wr_addr0", 32'(wa_q[0]), 32'd10);
      checkOutput("mb_wr_addr1", 32'(wa_q[1]), 32'd11);
      checkOutput("mb_wr_data1", 32'(wd_q[1]), 32'h1F);
    end

    // Wrap on write, WRAP=1 target.
    i2c_start();
    write_byte(8'hE0, a);
    write_byte(8'd126, a);
    write_byte(8'h12, a);
    write_byte(8'hFA, a);
    write_byte(8'h4D, a); checkOutput("wrap_last_ack", 32'(a), 32'd1);
    i2c_stop();
    #200;
    checkOutput("wrap_reg126", 32'(get_reg(0, 126)), 32'h12);
    checkOutput("wrap_reg127", 32'(get_reg(0, 127)), 32'hFA);
    checkOutput("wrap_reg0", 32'(get_reg(0, 0)), 32'h4D);

    // WRAP=0 target: second byte lands at 128, which is out of range.
    p0 = pulse_total;
    i2c_start();
    write_byte(8'hE2, a);
    write_byte(8'd127, a);
    write_byte(8'hFA, a);
    write_byte(8'h4D, a); checkOutput("nowrap_oor_ack", 32'(a), 32'd1);
    i2c_stop();
    #200;
    checkOutput("nowrap_reg127", 32'(get_reg(1, 127)), 32'hFA);
    checkOutput("nowrap_reg0", 32'(get_reg(1, 0)), 32'h00);
    checkOutput("nowrap_pulses", 32'(pulse_total - p0), 32'd1);

    // Read across the wrap point after a repeated START.
    i2c_start();
    write_byte(8'hE0, a);
    write_byte(8'd126, a);
    i2c_start();
    write_byte(8'hE1, a); checkOutput("rd_addr_ack", 32'(a), 32'd1);
    read_byte(1'b0, rb); checkOutput("rd_byte0", 32'(rb), 32'h12);
    read_byte(1'b0, rb); checkOutput("rd_byte1", 32'(rb), 32'hFA);
    read_byte(1'b1, rb); checkOutput("rd_byte2", 32'(rb), 32'h4D);
    checkOutput("rd_release_after_nak", 32'(oe0), 32'd0);
    checkOutput("rd_busy_before_stop", 32'(busy0), 32'd1);
    i2c_stop();
    #200;
    checkOutput("rd_busy_after_stop", 32'(busy0), 32'd0);

    // Out-of-range read on the 16-register target.
    i2c_start();
    write_byte(8'hE4, a);
    write_byte(8'd20, a);
    i2c_start();
    write_byte(8'hE5, a); checkOutput("oor_addr_ack", 32'(a), 32'd1);
    read_byte(1'b1, rb); checkOutput("oor_read", 32'(rb), 32'hFF);
    i2c_stop();
    #200;

    // STOP halfway through a data byte.
    p0 = pulse_total;
    i2c_start();
    write_byte(8'hE0, a);
    write_byte(8'd40, a);
    bit_cycle(1'b1, a);
    bit_cycle(1'b1, a);
    bit_cycle(1'b0, a);
    bit_cycle(1'b0, a);
    i2c_stop();
    #200;
    checkOutput("abort_reg40", 32'(get_reg(0, 40)), 32'h00);
    checkOutput("abort_pulses", 32'(pulse_total - p0), 32'd0);

    // Asynchronous reset while the target drives a read bit (reg10 = 0x55, MSB 0).
    i2c_start();
    write_byte(8'hE0, a);
    write_byte(8'd10, a);
    i2c_start();
    write_byte(8'hE1, a);
    checkOutput("mid_read_driving", 32'(oe0), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_sda_oe", 32'(oe0), 32'd0);
    checkOutput("async_rst_regs", 32'(|regs0), 32'd0);
    sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q rst_n = 1'b1;
    #200;
    checkOutput("post_rst_busy", 32'(busy0), 32'd0);
    checkOutput("wr_pulse_width", 32'(long_pulses), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
